// File: rtl/wb_burst_ram_if.sv
// Wishbone B3 registered-feedback bus bundle between a master and wb_burst_ram.
// The master drives the request side; the RAM returns read data and acknowledge.
interface wb_burst_ram_if;
    logic [31:0] wbs_dat_i;
    logic [31:2] wbs_adr_i;
    logic [3:0]  wbs_sel_i;
    logic [1:0]  wbs_bte_i;
    logic [2:0]  wbs_cti_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
        output wbs_we_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
        input  wbs_we_i, wbs_cyc_i, wbs_stb_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/wb_burst_ram.sv
// Single-port 32-bit Wishbone B3 RAM with classic cycles and linear/wrap bursts.
// Burst beats are streamed with zero bubbles by pre-reading the next beat's word.
module wb_burst_ram #(
    parameter int mem_adr_width = 10
) (
    input  logic          wbs_clk,
    input  logic          wbs_rst_n,
    wb_burst_ram_if.slave wbs
);
    localparam int depth = 2 ** mem_adr_width;

    typedef enum logic {
        IDLE = 1'b0,
        ACT  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [depth];

    logic [mem_adr_width-1:0] cnt, cnt_nxt, cnt_adv, rd_adr, req_adr;
    logic [1:0]  bte_r;
    logic        brst, we_r;
    logic        load, ack, wr_en, last_beat;
    logic [31:0] wr_word, dat_q;

    assign req_adr   = wbs.wbs_adr_i[mem_adr_width+1:2];
    assign last_beat = (wbs.wbs_cti_i == 3'b111);

    // Wrap bursts only roll the low counter bits; the upper bits stay on the aligned block.
    always_comb begin
        cnt_adv = cnt;
        case (bte_r)
            2'b00:   cnt_adv      = cnt + 1'b1;
            2'b01:   cnt_adv[1:0] = cnt[1:0] + 2'd1;
            2'b10:   cnt_adv[2:0] = cnt[2:0] + 3'd1;
            default: cnt_adv[3:0] = cnt[3:0] + 4'd1;
        endcase
    end

    always_ff @(posedge wbs_clk or negedge wbs_rst_n) begin
        if (!wbs_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A continuing burst beat reads the following word now, so it is ready on the next ack.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ack       = 1'b0;
        wr_en     = 1'b0;
        cnt_nxt   = cnt;
        rd_adr    = cnt;
        case (state)
            IDLE: begin
                if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                    state_nxt = ACT;
                    load      = 1'b1;
                    cnt_nxt   = req_adr;
                    rd_adr    = req_adr;
                end
            end
            ACT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (wbs.wbs_stb_i) begin
                    ack   = 1'b1;
                    wr_en = we_r;
                    if (!brst || last_beat) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_adv;
                        rd_adr  = cnt_adv;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_word = mem[cnt];
        for (int b = 0; b < 4; b++) begin
            if (wbs.wbs_sel_i[b]) begin
                wr_word[8*b +: 8] = wbs.wbs_dat_i[8*b +: 8];
            end
        end
    end

    // The bypass keeps a same-cycle write to the read address visible in the output register.
    always_ff @(posedge wbs_clk or negedge wbs_rst_n) begin
        if (!wbs_rst_n) begin
            cnt   <= '0;
            brst  <= 1'b0;
            bte_r <= 2'b00;
            we_r  <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            cnt <= cnt_nxt;
            if (load) begin
                brst  <= (wbs.wbs_cti_i == 3'b010);
                bte_r <= wbs.wbs_bte_i;
                we_r  <= wbs.wbs_we_i;
            end
            if (wr_en && (rd_adr == cnt)) begin
                dat_q <= wr_word;
            end else begin
                dat_q <= mem[rd_adr];
            end
        end
    end

    always_ff @(posedge wbs_clk) begin
        if (wr_en) begin
            mem[cnt] <= wr_word;
        end
    end

    assign wbs.wbs_ack_o = ack;
    assign wbs.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_wb_burst_ram.sv
// Self-checking bench for wb_burst_ram: a word-array model fed by per-beat address lists,
// a per-cycle compare process, and literal expectations for the directed scenarios.
module tb_wb_burst_ram;
    logic wbs_clk = 1'b0;
    logic wbs_rst_n;

    wb_burst_ram_if bus();

    wb_burst_ram #(.mem_adr_width(10)) dut (
        .wbs_clk   (wbs_clk),
        .wbs_rst_n (wbs_rst_n),
        .wbs       (bus)
    );

    always #5 wbs_clk = ~wbs_clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelMem [1024];
    int          expQ[$];
    logic [31:0] rdLog[$];
    logic [31:0] wrData[$];
    bit          expWe = 1'b0;
    bit          inData = 1'b0;
    int          lastCycles = 0;
    logic [31:0] rd;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Address of beat k: linear wraps the whole RAM, wrapN stays inside its aligned N-word block.
    function automatic int beatAddr(input int start, input logic [1:0] bte, input int k);
        int s;
        int size;
        s = start % 1024;
        if (bte == 2'b00) return (s + k) % 1024;
        size = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : 16;
        return (s - (s % size)) + ((s % size) + k) % size;
    endfunction

    always @(negedge wbs_clk) begin : compare
        int a;
        if (!wbs_rst_n) begin
            checkOutput("reset_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
            checkOutput("reset_dat", bus.wbs_dat_o, 32'h0);
        end else begin
            checkOutput("ack", {31'h0, bus.wbs_ack_o},
                        {31'h0, inData && bus.wbs_cyc_i && bus.wbs_stb_i && (expQ.size() > 0)});
            if (bus.wbs_ack_o && (expQ.size() > 0)) begin
                a = expQ.pop_front();
                if (expWe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.wbs_sel_i[b]) modelMem[a][8*b +: 8] = bus.wbs_dat_i[8*b +: 8];
                    end
                end else begin
                    checkOutput("rdata", bus.wbs_dat_o, modelMem[a]);
                    rdLog.push_back(bus.wbs_dat_o);
                end
            end
        end
    end

    task automatic applyStimulus(input bit we, input int adr, input logic [1:0] bte, input int nBeats,
                                 input bit burst, input logic [3:0] sel, input int gapA, input int gapB,
                                 input int gapLen, input int rstBeat);
        int  beat = 0;
        int  usedA = 0;
        int  usedB = 0;
        int  guard = 0;
        bit  got;
        expQ.delete();
        rdLog.delete();
        for (int k = 0; k < nBeats; k++) expQ.push_back(beatAddr(adr, bte, k));
        expWe = we;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = 30'(adr);
        bus.wbs_bte_i = bte;
        bus.wbs_sel_i = sel;
        bus.wbs_cti_i = !burst ? 3'b000 : (nBeats == 1) ? 3'b111 : 3'b010;
        bus.wbs_dat_i = we ? wrData[0] : 32'h0;
        @(posedge wbs_clk);
        #1;
        inData = 1'b1;
        lastCycles = 0;
        if (burst) begin
            bus.wbs_adr_i = 30'($urandom);
            bus.wbs_we_i  = !we;
        end
        while (beat < nBeats) begin
            if (guard > nBeats + 64) begin
                checkOutput("ack_timeout", beat, nBeats);
                break;
            end
            guard++;
            if (beat == rstBeat) begin
                wbs_rst_n = 1'b0;
                inData = 1'b0;
                expQ.delete();
                break;
            end
            bus.wbs_stb_i = 1'b1;
            if (beat == gapA && usedA < gapLen) begin
                bus.wbs_stb_i = 1'b0;
                usedA++;
            end else if (beat == gapB && usedB < gapLen) begin
                bus.wbs_stb_i = 1'b0;
                usedB++;
            end
            if (burst) bus.wbs_cti_i = (beat == nBeats - 1) ? 3'b111 : 3'b010;
            if (we) bus.wbs_dat_i = wrData[beat];
            @(negedge wbs_clk);
            got = bus.wbs_ack_o;
            lastCycles++;
            @(posedge wbs_clk);
            #1;
            if (got) beat++;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_cti_i = 3'b000;
        inData = 1'b0;
    endtask

    task automatic classicWrite(input int adr, input logic [31:0] d, input logic [3:0] sel);
        wrData.delete();
        wrData.push_back(d);
        applyStimulus(1'b1, adr, 2'b00, 1, 1'b0, sel, -1, -1, 0, -1);
    endtask

    task automatic classicRead(input int adr, output logic [31:0] d);
        applyStimulus(1'b0, adr, 2'b00, 1, 1'b0, 4'hF, -1, -1, 0, -1);
        d = (rdLog.size() > 0) ? rdLog[0] : 32'hXXXXXXXX;
    endtask

    logic [31:0] exp27 [8];
    logic [31:0] exp29 [16];

    initial begin
        exp27 = '{32'h3FC, 32'h3FD, 32'h3FE, 32'h3FF, 32'h000, 32'h001, 32'h002, 32'h003};
        exp29 = '{32'h1E, 32'h1F, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15,
                  32'h16, 32'h17, 32'h18, 32'h19, 32'h1A, 32'h1B, 32'h1C, 32'h1D};
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_sel_i = '0;
        bus.wbs_bte_i = '0;
        bus.wbs_cti_i = '0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        wbs_rst_n = 1'b1;
        #1 wbs_rst_n = 1'b0;
        repeat (3) @(posedge wbs_clk);
        #1 wbs_rst_n = 1'b1;

        checkOutput("model_pin_wrap16", beatAddr('h1E, 2'b11, 2), 32'h10);
        checkOutput("model_pin_wrap4", beatAddr('h06, 2'b01, 3), 32'h05);

        $display("[TB] preload: linear write burst of 1024 words");
        wrData.delete();
        for (int i = 0; i < 1024; i++) wrData.push_back(32'(i));
        applyStimulus(1'b1, 0, 2'b00, 1024, 1'b1, 4'hF, -1, -1, 0, -1);
        checkOutput("preload_cycles", lastCycles, 1024);
        checkOutput("model_pin_3fc", modelMem[10'h3FC], 32'h3FC);

        $display("[TB] linear read burst across the top of the RAM");
        applyStimulus(1'b0, 'h3FC, 2'b00, 8, 1'b1, 4'hF, -1, -1, 0, -1);
        checkOutput("lin8_cycles", lastCycles, 8);
        checkOutput("lin8_count", rdLog.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("lin8_beat%0d", i), rdLog[i], exp27[i]);

        $display("[TB] wrap16 read with stb wait states");
        applyStimulus(1'b0, 'h1E, 2'b11, 16, 1'b1, 4'hF, 3, 7, 2, -1);
        checkOutput("wrap16_cycles", lastCycles, 20);
        checkOutput("wrap16_count", rdLog.size(), 16);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("wrap16_beat%0d", i), rdLog[i], exp29[i]);

        $display("[TB] classic write then classic read");
        classicWrite('h10, 32'hDEADBEEF, 4'hF);
        checkOutput("classic_wr_cycles", lastCycles, 1);
        classicRead('h10, rd);
        checkOutput("classic_rd_cycles", lastCycles, 1);
        checkOutput("classic_rd_data", rd, 32'hDEADBEEF);

        $display("[TB] wrap4 write burst then readback");
        wrData = '{32'd1, 32'd2, 32'd3, 32'd4};
        applyStimulus(1'b1, 'h06, 2'b01, 4, 1'b1, 4'hF, -1, -1, 0, -1);
        checkOutput("wrap4_cycles", lastCycles, 4);
        checkOutput("model_pin_w4", modelMem[4], 32'd3);
        classicRead('h06, rd); checkOutput("wrap4_rd06", rd, 32'd1);
        classicRead('h07, rd); checkOutput("wrap4_rd07", rd, 32'd2);
        classicRead('h04, rd); checkOutput("wrap4_rd04", rd, 32'd3);
        classicRead('h05, rd); checkOutput("wrap4_rd05", rd, 32'd4);

        $display("[TB] byte enables");
        classicWrite('h20, 32'hFFFFFFFF, 4'hF);
        classicWrite('h20, 32'h0000AB00, 4'b0010);
        classicRead('h20, rd);
        checkOutput("byte_merge", rd, 32'hFFFFABFF);
        classicWrite('h21, 32'h12345678, 4'b0000);
        checkOutput("sel0_cycles", lastCycles, 1);
        classicRead('h21, rd);
        checkOutput("sel0_nochange", rd, 32'h21);

        $display("[TB] reset during a wrap8 write burst");
        wrData = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        applyStimulus(1'b1, 'h40, 2'b10, 8, 1'b1, 4'hF, -1, -1, 0, 2);
        @(negedge wbs_clk);
        checkOutput("rst_mid_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        checkOutput("rst_mid_dat", bus.wbs_dat_o, 32'h0);
        @(negedge wbs_clk);
        #1 wbs_rst_n = 1'b1;
        classicRead('h40, rd);
        checkOutput("post_rst_cycles", lastCycles, 1);
        checkOutput("post_rst_rd40", rd, 32'hA0);
        classicRead('h41, rd); checkOutput("post_rst_rd41", rd, 32'hA1);
        classicRead('h42, rd); checkOutput("post_rst_rd42", rd, 32'h42);

        repeat (2) @(posedge wbs_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
